// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter and access sequencer for the single-port main RAM.
// The CPU port and the DMA/loader port share the RAM. One access runs at a time
// through IDLE -> ACC -> (WAIT) -> DONE, with a one-cycle done pulse to the owner.
// Optional feature macro: MEMARB_STARVE_EN builds the DMA starvation counter;
// without it the CPU has strict priority.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  // CPU port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  // DMA port
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_done,
  // RAM side
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {StIdle, StAcc, StWait, StDone} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;  // 1 = DMA owns the current access
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [2:0]          lat_q, lat_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;

  logic                starve_flag;
  logic                grant_dma;
  logic                grant_cpu;

  // Arbitration: DMA wins when it is alone or when it has waited too long.
  assign grant_dma = (state_q == StIdle) && dma_req && (!cpu_req || starve_flag);
  assign grant_cpu = (state_q == StIdle) && cpu_req && !grant_dma;

`ifdef MEMARB_STARVE_EN
  logic [7:0] starve_q, starve_d;
  logic       dma_owns;

  assign dma_owns    = (state_q != StIdle) && owner_q;
  assign starve_flag = (32'(starve_q) >= STARVE_MAX);

  // Saturating count of cycles DMA has been kept waiting; cleared on its grant.
  always_comb begin
    starve_d = starve_q;
    if (grant_dma) begin
      starve_d = '0;
    end else if (dma_req && !dma_owns && (starve_q != 8'hFF)) begin
      starve_d = starve_q + 8'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  // Strict CPU priority; the limit only matters when the counter is built.
  assign starve_flag = 1'b0 & (STARVE_MAX != 0);
`endif

  // Next-state and datapath capture for the access sequencer.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lat_d       = lat_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (grant_dma) begin
          owner_d = 1'b1;
          we_d    = dma_we;
          addr_d  = dma_addr;
          wdata_d = dma_wdata;
          state_d = StAcc;
        end else if (grant_cpu) begin
          owner_d = 1'b0;
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          state_d = StAcc;
        end
      end
      StAcc: begin
        if (we_q) begin
          state_d = StDone;
        end else begin
          lat_d   = 3'(READ_LAT);
          state_d = StWait;
        end
      end
      StWait: begin
        // Count 1 is the cycle in which the RAM presents the read word.
        if (lat_q == 3'd1) begin
          if (owner_q) begin
            dma_rdata_d = ram_rdata;
          end else begin
            cpu_rdata_d = ram_rdata;
          end
          state_d = StDone;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and latched access registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_q       <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lat_q       <= lat_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // RAM strobes and completion outputs decoded from the state register, so an
  // asynchronous reset clears them immediately.
  always_comb begin
    ram_we    = (state_q == StAcc) && we_q;
    ram_re    = (state_q == StAcc) && !we_q;
    ram_addr  = (state_q == StIdle) ? '0 : addr_q;
    ram_wdata = (state_q == StIdle) ? '0 : wdata_q;
    cpu_done  = (state_q == StDone) && !owner_q;
    dma_done  = (state_q == StDone) && owner_q;
    cpu_stall = cpu_req && !cpu_done;
    cpu_rdata = cpu_rdata_q;
    dma_rdata = dma_rdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a latency-modelled RAM and a
// per-port scoreboard of expected done cycles and read data.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W     = 9;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned READ_LAT   = 3;
  localparam int unsigned STARVE_MAX = 4;
  localparam int          WriteLat   = 2;
  localparam int          ReadLat    = 2 + READ_LAT;

  logic              Clock;
  logic              Reset;
  logic              cpu_req, cpu_we, cpu_done, cpu_stall;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              dma_req, dma_we, dma_done;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata, dma_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic              ram_we, ram_re;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [DATA_W-1:0] data;
    bit                chk;
    int                cyc;
  } exp_t;

  exp_t              cpu_q[$];
  exp_t              dma_q[$];
  logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];
  logic              prev_strobe = 1'b0;

  mem_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .READ_LAT  (READ_LAT),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_done (cpu_done),
    .cpu_stall(cpu_stall),
    .dma_req  (dma_req),
    .dma_we   (dma_we),
    .dma_addr (dma_addr),
    .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata),
    .dma_done (dma_done),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_we   (ram_we),
    .ram_re   (ram_re),
    .ram_rdata(ram_rdata)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  // RAM model: synchronous write, read word appears READ_LAT cycles after ram_re.
  logic [DATA_W-1:0] ram_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_pipe [0:READ_LAT-1];
  always @(posedge Clock) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    rd_pipe[0] <= ram_re ? ram_mem[ram_addr] : 32'hBAD0_BAD0;
    for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rdata = rd_pipe[READ_LAT-1];

  // Monitor: per-cycle invariants and scoreboard pops on done pulses.
  always @(negedge Clock) begin
    exp_t e;
    if (!Reset) begin
      prev_strobe = 1'b0;
    end else begin
      checks++;
      if (cpu_stall !== (cpu_req & ~cpu_done)) begin
        failures++;
        $display("FAIL cpu_stall cyc=%0d: got %b required %b", cyc, cpu_stall,
                 cpu_req & ~cpu_done);
      end
      checks++;
      if ((ram_we & ram_re) !== 1'b0) begin
        failures++;
        $display("FAIL strobe_overlap cyc=%0d: we=%b re=%b required not both", cyc, ram_we, ram_re);
      end
      checks++;
      if (((ram_we | ram_re) & prev_strobe) !== 1'b0) begin
        failures++;
        $display("FAIL strobe_width cyc=%0d: strobe high two cycles, required one", cyc);
      end
      prev_strobe = ram_we | ram_re;
      if (cpu_done === 1'b1) begin
        checks++;
        if (cpu_q.size() == 0) begin
          failures++;
          $display("FAIL cpu_done_unexpected cyc=%0d: got done=1 required 0", cyc);
        end else begin
          e = cpu_q.pop_front();
          if (e.cyc >= 0) begin
            checks++;
            if (cyc != e.cyc) begin
              failures++;
              $display("FAIL cpu_done_cycle: got %0d required %0d", cyc, e.cyc);
            end
          end
          if (e.chk) begin
            checks++;
            if (cpu_rdata !== e.data) begin
              failures++;
              $display("FAIL cpu_rdata cyc=%0d: got %h required %h", cyc, cpu_rdata, e.data);
            end
          end
        end
      end
      if (dma_done === 1'b1) begin
        checks++;
        if (dma_q.size() == 0) begin
          failures++;
          $display("FAIL dma_done_unexpected cyc=%0d: got done=1 required 0", cyc);
        end else begin
          e = dma_q.pop_front();
          if (e.cyc >= 0) begin
            checks++;
            if (cyc != e.cyc) begin
              failures++;
              $display("FAIL dma_done_cycle: got %0d required %0d", cyc, e.cyc);
            end
          end
          if (e.chk) begin
            checks++;
            if (dma_rdata !== e.data) begin
              failures++;
              $display("FAIL dma_rdata cyc=%0d: got %h required %h", cyc, dma_rdata, e.data);
            end
          end
        end
      end
    end
  end

  // Drives one access on a port, pushes its expectation, waits for done (bounded).
  // Called just after a rising edge; with keep=1 the request stays asserted.
  task automatic access(input bit is_dma, input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input int lat, input bit keep,
                        output int done_cyc);
    exp_t e;
    bit   seen;
    e.chk  = !we;
    e.data = we ? '0 : shadow[addr];
    if (we) shadow[addr] = wdata;
    e.cyc  = (lat < 0) ? -1 : cyc + lat;
    if (is_dma) begin
      dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
      dma_q.push_back(e);
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      cpu_q.push_back(e);
    end
    seen     = 1'b0;
    done_cyc = -1;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge Clock);
      if (is_dma ? dma_done : cpu_done) begin
        seen     = 1'b1;
        done_cyc = cyc;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL access_timeout dma=%0b addr=%h: got no done, required done", is_dma, addr);
    end
    @(posedge Clock);
    #1;
    if (!keep) begin
      if (is_dma) dma_req = 1'b0;
      else cpu_req = 1'b0;
    end
  endtask

  task automatic test_reset;
    Reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    #12;
    checks++; if (cpu_done !== 1'b0) begin failures++; $display("FAIL rst_cpu_done: got %b required 0", cpu_done); end
    checks++; if (dma_done !== 1'b0) begin failures++; $display("FAIL rst_dma_done: got %b required 0", dma_done); end
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL rst_cpu_stall: got %b required 0", cpu_stall); end
    checks++; if (cpu_rdata !== '0) begin failures++; $display("FAIL rst_cpu_rdata: got %h required 0", cpu_rdata); end
    checks++; if (dma_rdata !== '0) begin failures++; $display("FAIL rst_dma_rdata: got %h required 0", dma_rdata); end
    checks++; if ({ram_we, ram_re} !== 2'b00) begin failures++; $display("FAIL rst_strobes: got %b required 00", {ram_we, ram_re}); end
    checks++; if (ram_addr !== '0) begin failures++; $display("FAIL rst_ram_addr: got %h required 0", ram_addr); end
    checks++; if (ram_wdata !== '0) begin failures++; $display("FAIL rst_ram_wdata: got %h required 0", ram_wdata); end
    @(posedge Clock); #1;
    Reset = 1'b1;
    @(posedge Clock); #1;
  endtask

  task automatic test_write_read;
    int d;
    fork
      access(1'b0, 1'b1, 9'h005, 32'hDEAD_BEEF, WriteLat, 1'b0, d);
      begin
        @(negedge Clock);
        checks++; if (ram_addr !== '0) begin failures++; $display("FAIL idle_ram_addr: got %h required 0", ram_addr); end
        @(negedge Clock);
        checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL acc_ram_we: got %b required 1", ram_we); end
        checks++; if (ram_addr !== 9'h005) begin failures++; $display("FAIL acc_ram_addr: got %h required 005", ram_addr); end
        checks++; if (ram_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL acc_ram_wdata: got %h required deadbeef", ram_wdata); end
      end
    join
    fork
      access(1'b1, 1'b0, 9'h005, '0, ReadLat, 1'b0, d);
      begin
        @(negedge Clock);
        @(negedge Clock);
        checks++; if ({ram_re, ram_we} !== 2'b10) begin failures++; $display("FAIL acc_ram_re: got re,we=%b required 10", {ram_re, ram_we}); end
        checks++; if (ram_addr !== 9'h005) begin failures++; $display("FAIL acc_rd_addr: got %h required 005", ram_addr); end
      end
    join
    checks++; if (dma_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL dma_rdata_hold: got %h required deadbeef", dma_rdata); end
    checks++; if (cpu_rdata !== '0) begin failures++; $display("FAIL cpu_rdata_untouched: got %h required 0", cpu_rdata); end
  endtask

  task automatic test_simultaneous;
    int dc, dd;
    fork
      access(1'b0, 1'b1, 9'h010, 32'h1111_0010, WriteLat, 1'b0, dc);
      access(1'b1, 1'b1, 9'h011, 32'h2222_0011, WriteLat + 3, 1'b0, dd);
    join
    checks++; if (dd - dc != 3) begin failures++; $display("FAIL sim_done_gap: got %0d required 3", dd - dc); end
    access(1'b0, 1'b0, 9'h011, '0, ReadLat, 1'b0, dc);
    access(1'b1, 1'b0, 9'h010, '0, ReadLat, 1'b0, dd);
  endtask

  task automatic test_back_to_back;
    int d;
    for (int i = 0; i < 4; i++)
      access(1'b0, 1'b1, 9'(9'h020 + i), $urandom, WriteLat, i != 3, d);
    for (int i = 0; i < 4; i++)
      access(1'b0, 1'b0, 9'(9'h020 + i), '0, ReadLat, i != 3, d);
    for (int i = 0; i < 3; i++)
      access(1'b1, 1'b0, 9'(9'h021 + i), '0, ReadLat, i != 2, d);
  endtask

  task automatic test_starve;
    int d, s, dd;
    bit dma_fin;
    dma_fin = 1'b0;
`ifdef MEMARB_STARVE_EN
    fork
      begin
        access(1'b0, 1'b1, 9'h030, 32'hC0DE_0030, WriteLat, 1'b1, d);
        access(1'b0, 1'b1, 9'h031, 32'hC0DE_0031, WriteLat, 1'b1, d);
        for (int i = 2; !dma_fin && i < 40; i++)
          access(1'b0, 1'b1, 9'(9'h030 + i), $urandom, -1, 1'b1, d);
        cpu_req = 1'b0;
      end
      begin
        access(1'b1, 1'b1, 9'h038, 32'hD4A0_0038, WriteLat + 6, 1'b0, dd);
        dma_fin = 1'b1;
      end
      begin
        repeat (7) @(negedge Clock);
        checks++; if (dut.starve_q !== 8'd6) begin failures++; $display("FAIL starve_cnt_before: got %0d required 6", dut.starve_q); end
        @(negedge Clock);
        checks++; if (dut.starve_q !== 8'd0) begin failures++; $display("FAIL starve_cnt_after: got %0d required 0", dut.starve_q); end
        checks++; if (ram_addr !== 9'h038) begin failures++; $display("FAIL starve_grant_addr: got %h required 038", ram_addr); end
      end
    join
`else
    fork
      begin
        for (int i = 0; i < 34; i++)
          access(1'b0, 1'b1, 9'(9'h080 + i), $urandom, WriteLat, 1'b1, d);
        s = cyc;
        cpu_req = 1'b0;
      end
      access(1'b1, 1'b1, 9'h0FF, 32'hD4A0_00FF, -1, 1'b0, dd);
    join
    checks++; if (dd != s + 2) begin failures++; $display("FAIL strict_prio_dma_done: got cycle %0d required %0d", dd, s + 2); end
`endif
    access(1'b1, 1'b0, 9'h031, '0, ReadLat, 1'b0, d);
  endtask

  task automatic test_reset_mid_read;
    int d;
    access(1'b0, 1'b1, 9'h040, 32'h1234_5678, WriteLat, 1'b0, d);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h040;
    repeat (3) @(negedge Clock);  // IDLE, ACC, first WAIT cycle
    #1;
    Reset = 1'b0;
    cpu_req = 1'b0;
    #1;
    checks++; if ({cpu_done, dma_done, ram_we, ram_re} !== 4'b0000) begin failures++; $display("FAIL midrst_strobes: got %b required 0000", {cpu_done, dma_done, ram_we, ram_re}); end
    checks++; if (ram_addr !== '0) begin failures++; $display("FAIL midrst_ram_addr: got %h required 0", ram_addr); end
    checks++; if (cpu_rdata !== '0) begin failures++; $display("FAIL midrst_cpu_rdata: got %h required 0", cpu_rdata); end
    checks++; if (dma_rdata !== '0) begin failures++; $display("FAIL midrst_dma_rdata: got %h required 0", dma_rdata); end
    repeat (3) begin
      @(negedge Clock);
      checks++; if ({cpu_done, dma_done} !== 2'b00) begin failures++; $display("FAIL midrst_done: got %b required 00", {cpu_done, dma_done}); end
    end
    @(posedge Clock); #1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    access(1'b0, 1'b0, 9'h040, '0, ReadLat, 1'b0, d);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_simultaneous();
    test_back_to_back();
    test_starve();
    test_reset_mid_read();
    repeat (4) @(posedge Clock);
    checks++;
    if (cpu_q.size() + dma_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", cpu_q.size() + dma_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
